// File: rtl/mbgd_apb_slave_if.sv
// APB bus bundle between the MBGD config master and mbgd_apb_slave.
// apb_pslverr exists only when MBGD_APB_SLVERR_EN is defined.
interface mbgd_apb_slave_if;
  logic       apb_psel;
  logic       apb_penable;
  logic       apb_pwrite;
  logic [7:0] apb_paddress;
  logic [7:0] apb_pwdata;
  logic [7:0] prdata;
  logic       apb_pready;
`ifdef MBGD_APB_SLVERR_EN
  logic       apb_pslverr;
`endif

  modport master (
    output apb_psel, apb_penable, apb_pwrite, apb_paddress, apb_pwdata,
    input  prdata, apb_pready
`ifdef MBGD_APB_SLVERR_EN
    , input apb_pslverr
`endif
  );

  modport slave (
    input  apb_psel, apb_penable, apb_pwrite, apb_paddress, apb_pwdata,
    output prdata, apb_pready
`ifdef MBGD_APB_SLVERR_EN
    , output apb_pslverr
`endif
  );
endinterface

// File: rtl/mbgd_apb_slave.sv
// APB slave holding NUM_REGS 8-bit config registers for the MBGD core, with
// WAIT_CYCLES wait states per transfer. Define MBGD_APB_SLVERR_EN for apb_pslverr.
module mbgd_apb_slave #(
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic            apb_pclk,
  input  logic            reset,
  mbgd_apb_slave_if.slave bus,
  output logic [1:0]      state,
  output logic [7:0]      cfg_reg0,
  output logic [7:0]      cfg_reg1
);
  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SETUP  = 2'b01,
    S_ACCESS = 2'b10
  } state_e;

  localparam logic [8:0] LP_NREGS = 9'(NUM_REGS);
  localparam logic [3:0] LP_WAIT  = 4'(WAIT_CYCLES);

  state_e                     r_state;
  logic [3:0]                 r_wait;
  logic [NUM_REGS-1:0][7:0]   r_regs;
  logic                       w_in_range;
  logic                       w_ready;
  logic                       w_commit;
  logic [7:0]                 w_rd_sel;

  assign w_in_range = {1'b0, bus.apb_paddress} < LP_NREGS;
  assign w_ready    = (r_state == S_ACCESS) && (r_wait == 4'd0);
  // psel low in the ready cycle is an abort, so it never commits.
  assign w_commit   = w_ready && bus.apb_psel && bus.apb_pwrite && w_in_range;

  always_ff @(posedge apb_pclk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_wait  <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.apb_psel && !bus.apb_penable) r_state <= S_SETUP;
        end
        S_SETUP: begin
          if (!bus.apb_psel) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_ACCESS;
            r_wait  <= LP_WAIT;
          end
        end
        S_ACCESS: begin
          if (!bus.apb_psel) begin
            r_state <= S_IDLE;
            r_wait  <= 4'd0;
          end else if (r_wait != 4'd0) begin
            r_wait <= r_wait - 4'd1;
          end else begin
            // penable dropped in the completion cycle chains straight into SETUP
            r_state <= bus.apb_penable ? S_IDLE : S_SETUP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge apb_pclk or posedge reset) begin
    if (reset) begin
      r_regs <= '0;
    end else if (w_commit) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (bus.apb_paddress == 8'(i)) r_regs[i] <= bus.apb_pwdata;
    end
  end

  always_comb begin
    w_rd_sel = 8'h00;
    for (int i = 0; i < NUM_REGS; i++)
      if (bus.apb_paddress == 8'(i)) w_rd_sel = r_regs[i];
  end

  assign bus.prdata     = (r_state == S_ACCESS && !bus.apb_pwrite) ? w_rd_sel : 8'h00;
  assign bus.apb_pready = w_ready;
`ifdef MBGD_APB_SLVERR_EN
  assign bus.apb_pslverr = w_ready && !w_in_range;
`endif

  assign state    = r_state;
  assign cfg_reg0 = r_regs[0];
  if (NUM_REGS > 1) begin : g_cfg1
    assign cfg_reg1 = r_regs[1];
  end else begin : g_cfg1_none
    assign cfg_reg1 = 8'h00;
  end
endmodule

// File: tb/tb_mbgd_apb_slave.sv
// Bench for mbgd_apb_slave: one instance with no wait states, one with two,
// checked every cycle against a transfer-level model plus literal expectations.
module tb_mbgd_apb_slave;
  localparam int NR = 16;
  localparam logic [1:0] ST_IDLE = 2'b00, ST_SETUP = 2'b01, ST_ACC = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mbgd_apb_slave_if bus0 ();
  mbgd_apb_slave_if bus2 ();
  logic [1:0] st0, st2;
  logic [7:0] c00, c01, c20, c21;

  mbgd_apb_slave #(.NUM_REGS(NR), .WAIT_CYCLES(0)) u_dut0 (
    .apb_pclk(clk), .reset(rst), .bus(bus0), .state(st0), .cfg_reg0(c00), .cfg_reg1(c01));
  mbgd_apb_slave #(.NUM_REGS(NR), .WAIT_CYCLES(2)) u_dut2 (
    .apb_pclk(clk), .reset(rst), .bus(bus2), .state(st2), .cfg_reg0(c20), .cfg_reg1(c21));

  logic [1:0] d_psel, d_pen, d_wr;
  logic [7:0] d_addr  [2];
  logic [7:0] d_wdata [2];
  assign bus0.apb_psel     = d_psel[0];
  assign bus0.apb_penable  = d_pen[0];
  assign bus0.apb_pwrite   = d_wr[0];
  assign bus0.apb_paddress = d_addr[0];
  assign bus0.apb_pwdata   = d_wdata[0];
  assign bus2.apb_psel     = d_psel[1];
  assign bus2.apb_penable  = d_pen[1];
  assign bus2.apb_pwrite   = d_wr[1];
  assign bus2.apb_paddress = d_addr[1];
  assign bus2.apb_pwdata   = d_wdata[1];

  // model: expected outputs for the current cycle and the register contents
  logic [1:0] e_st  [2];
  logic       e_rdy [2];
  logic [7:0] e_rd  [2];
  logic       e_err [2];
  logic [7:0] mem   [2][NR];
  logic [7:0] last_rd [2];

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int d, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %02h want %02h at %0t", nm, d, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state",  0, 8'(st0),             8'(e_st[0]));
      chk("pready", 0, 8'(bus0.apb_pready), 8'(e_rdy[0]));
      chk("prdata", 0, bus0.prdata,         e_rd[0]);
      chk("cfg0",   0, c00,                 mem[0][0]);
      chk("cfg1",   0, c01,                 mem[0][1]);
      chk("state",  1, 8'(st2),             8'(e_st[1]));
      chk("pready", 1, 8'(bus2.apb_pready), 8'(e_rdy[1]));
      chk("prdata", 1, bus2.prdata,         e_rd[1]);
      chk("cfg0",   1, c20,                 mem[1][0]);
      chk("cfg1",   1, c21,                 mem[1][1]);
`ifdef MBGD_APB_SLVERR_EN
      chk("pslverr", 0, 8'(bus0.apb_pslverr), 8'(e_err[0]));
      chk("pslverr", 1, 8'(bus2.apb_pslverr), 8'(e_err[1]));
`endif
      if (bus0.apb_pready) last_rd[0] = bus0.prdata;
      if (bus2.apb_pready) last_rd[1] = bus2.prdata;
    end
  end

  task automatic setdrv(input int d, input bit ps, input bit pe, input bit wr,
                        input logic [7:0] a, input logic [7:0] wd, input logic [1:0] est,
                        input bit erdy, input logic [7:0] erd, input bit eerr);
    for (int i = 0; i < 2; i++) begin
      d_psel[i] = 1'b0; d_pen[i] = 1'b0;
      e_st[i] = ST_IDLE; e_rdy[i] = 1'b0; e_rd[i] = 8'h00; e_err[i] = 1'b0;
    end
    d_psel[d] = ps; d_pen[d] = pe; d_wr[d] = wr; d_addr[d] = a; d_wdata[d] = wd;
    e_st[d] = est; e_rdy[d] = erdy; e_rd[d] = erd; e_err[d] = eerr;
  endtask

  task automatic cyc(input int d, input bit ps, input bit pe, input bit wr,
                     input logic [7:0] a, input logic [7:0] wd, input logic [1:0] est,
                     input bit erdy, input logic [7:0] erd, input bit eerr);
    setdrv(d, ps, pe, wr, a, wd, est, erdy, erd, eerr);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, ST_IDLE, 1'b0, 8'h00, 1'b0);
  endtask

  // One transfer on instance d. drop_at: -1 none, 0 drop psel in SETUP,
  // k+1 drop psel in ACCESS cycle k (only before the ready cycle).
  task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                      input bit b2b_in, input bit b2b_out, input int drop_at);
    int w;
    logic [7:0] rd;
    bit oor;
    w   = (d == 0) ? 0 : 2;
    oor = (a >= 8'(NR));
    rd  = (!wr && !oor) ? mem[d][a[3:0]] : 8'h00;
    if (!b2b_in) cyc(d, 1'b1, 1'b0, wr, a, wd, ST_IDLE, 1'b0, 8'h00, 1'b0);
    if (drop_at == 0) begin
      cyc(d, 1'b0, 1'b1, wr, a, wd, ST_SETUP, 1'b0, 8'h00, 1'b0);
      return;
    end
    cyc(d, 1'b1, 1'b1, wr, a, wd, ST_SETUP, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k <= w; k++) begin
      if (drop_at == k + 1) begin
        cyc(d, 1'b0, 1'b1, wr, a, wd, ST_ACC, 1'b0, rd, 1'b0);
        return;
      end
      cyc(d, 1'b1, (k == w && b2b_out) ? 1'b0 : 1'b1, wr, a, wd, ST_ACC,
          k == w, rd, (k == w) && oor);
    end
    if (wr && !oor) mem[d][a[3:0]] = wd;
  endtask

  task automatic clear_mem();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NR; i++) mem[d][i] = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    clear_mem();
    last_rd[0] = 8'h00; last_rd[1] = 8'h00;
    for (int i = 0; i < 2; i++) begin d_wr[i] = 1'b0; d_addr[i] = 8'h00; d_wdata[i] = 8'h00; end
    setdrv(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, ST_IDLE, 1'b0, 8'h00, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("rst_state_lit",  0, 8'(st0), 8'h00);
    chk("rst_pready_lit", 1, 8'(bus2.apb_pready), 8'h00);
    chk("rst_prdata_lit", 0, bus0.prdata, 8'h00);
    chk("rst_cfg0_lit",   0, c00, 8'h00);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // zero-wait write/read pair
    xfer(0, 1'b1, 8'h00, 8'hEE, 1'b0, 1'b0, -1);
    xfer(0, 1'b1, 8'h01, 8'hCC, 1'b0, 1'b0, -1);
    xfer(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, -1);
    chk("rd0_lit", 0, last_rd[0], 8'hEE);
    xfer(0, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, -1);
    chk("rd1_lit", 0, last_rd[0], 8'hCC);
    chk("cfg0_lit", 0, c00, 8'hEE);
    chk("cfg1_lit", 0, c01, 8'hCC);

    // IDLE with psel and penable both high is not a transfer start
    cyc(0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, ST_IDLE, 1'b0, 8'h00, 1'b0);
    idle(1);

    // abort in SETUP leaves register 2 untouched
    xfer(0, 1'b1, 8'h02, 8'h99, 1'b0, 1'b0, 0);
    xfer(0, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, -1);
    chk("abort_rd2_lit", 0, last_rd[0], 8'h00);

    // back-to-back writes then readback
    xfer(0, 1'b1, 8'h04, 8'h11, 1'b0, 1'b1, -1);
    xfer(0, 1'b1, 8'h05, 8'h22, 1'b1, 1'b0, -1);
    xfer(0, 1'b0, 8'h04, 8'h00, 1'b0, 1'b1, -1);
    chk("b2b_rd4_lit", 0, last_rd[0], 8'h11);
    xfer(0, 1'b0, 8'h05, 8'h00, 1'b1, 1'b0, -1);
    chk("b2b_rd5_lit", 0, last_rd[0], 8'h22);

    // address range edges
    xfer(0, 1'b1, 8'h0F, 8'hA5, 1'b0, 1'b0, -1);
    xfer(0, 1'b0, 8'h0F, 8'h00, 1'b0, 1'b0, -1);
    chk("rd_top_lit", 0, last_rd[0], 8'hA5);
    xfer(0, 1'b1, 8'h20, 8'h55, 1'b0, 1'b0, -1);
    xfer(0, 1'b1, 8'h10, 8'h66, 1'b0, 1'b0, -1);
    xfer(0, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, -1);
    chk("rd_oor_lit", 0, last_rd[0], 8'h00);
    xfer(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, -1);
    chk("oor_no_alias_lit", 0, last_rd[0], 8'hEE);

    // two wait states
    xfer(1, 1'b1, 8'h01, 8'hCC, 1'b0, 1'b0, -1);
    xfer(1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, -1);
    chk("w2_rd1_lit", 1, last_rd[1], 8'hCC);
    xfer(1, 1'b1, 8'h06, 8'h5A, 1'b0, 1'b0, 1);
    xfer(1, 1'b0, 8'h06, 8'h00, 1'b0, 1'b0, -1);
    chk("w2_abort_rd6_lit", 1, last_rd[1], 8'h00);
    xfer(1, 1'b1, 8'h07, 8'h3C, 1'b0, 1'b1, -1);
    xfer(1, 1'b0, 8'h07, 8'h00, 1'b1, 1'b0, -1);
    chk("w2_b2b_rd7_lit", 1, last_rd[1], 8'h3C);
    xfer(1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, -1);
    chk("w2_rd_oor_lit", 1, last_rd[1], 8'h00);

    // reset pulsed in ACCESS of write 0x03<-0x77
    cyc(0, 1'b1, 1'b0, 1'b1, 8'h03, 8'h77, ST_IDLE, 1'b0, 8'h00, 1'b0);
    cyc(0, 1'b1, 1'b1, 1'b1, 8'h03, 8'h77, ST_SETUP, 1'b0, 8'h00, 1'b0);
    setdrv(0, 1'b1, 1'b1, 1'b1, 8'h03, 8'h77, ST_ACC, 1'b1, 8'h00, 1'b0);
    @(negedge clk); #1;
    rst = 1'b1;
    clear_mem();
    setdrv(0, 1'b0, 1'b0, 1'b0, 8'h03, 8'h00, ST_IDLE, 1'b0, 8'h00, 1'b0);
    #1;
    chk("midrst_state_lit",  0, 8'(st0), 8'h00);
    chk("midrst_pready_lit", 0, 8'(bus0.apb_pready), 8'h00);
    chk("midrst_cfg0_lit",   0, c00, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    xfer(0, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0, -1);
    chk("midrst_rd3_lit", 0, last_rd[0], 8'h00);
    xfer(1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, -1);
    chk("midrst_w2_rd1_lit", 1, last_rd[1], 8'h00);
    idle(2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
